uart_rx: RTL and testbench

UART receive path of the APB UART. Consumes the oversampling `tick` from baud_generator and deserialises the `rx` line into parallel bytes. Frames are LSB-first with 1 start bit, 5–8 data bits, optional parity and 1 stop bit. Presents each received byte to the APB register block with a valid/ack handshake and error flags.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync.sv | 29 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } uart_rx_state_t;

   typedef logic [1:0] uart_data_len_t;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Data bit count for a data_len code: 00=5, 01=6, 10=7, 11=8.
   function automatic logic [3:0] len_to_bits(input uart_data_len_t len);
      return 4'd5 + {2'b00, len};
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for asynchronous UART inputs; resets to the idle line level.
module uart_sync
   import uart_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr <= {STAGES{UART_IDLE_LEVEL}};
      end else begin
         sr[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 5-8 data bits LSB first, optional parity, 1 stop bit.
// Parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic                 rx,
   input  uart_data_len_t       data_len,
   input  logic                 rx_ack,
`ifdef UART_RX_PARITY_EN
   input  logic                 parity_en,
   input  logic                 parity_odd,
`endif
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   output logic                 frame_error,
   output logic                 overrun_error,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_error,
`endif
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

   uart_rx_state_t state;
   logic [TW-1:0]  tcnt;
   logic [2:0]     bcnt;
   uart_data_len_t len_q;
   logic [7:0]     shreg;
   logic [2:0]     last_bit;
   logic           rx_s;
`ifdef UART_RX_PARITY_EN
   logic           par_en_q;
   logic           par_odd_q;
   logic           par_bit;
`endif

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   assign last_bit = 3'(len_to_bits(len_q) - 4'd1);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         tcnt          <= '0;
         bcnt          <= '0;
         len_q         <= '0;
         shreg         <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_en_q      <= 1'b0;
         par_odd_q     <= 1'b0;
         par_bit       <= 1'b0;
         parity_error  <= 1'b0;
`endif
      end else begin
         // Acknowledge clears flags; a completion later in this block overrides it.
         if (rx_ack) begin
            rx_valid      <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
         end

         case (state)
            IDLE: begin
               if (rx_s != UART_IDLE_LEVEL) begin
                  state <= START;
                  tcnt  <= '0;
               end
            end

            START: begin
               if (tick) begin
                  if (tcnt == T_MID) begin
                     if (rx_s != UART_IDLE_LEVEL) begin
                        len_q <= data_len;
`ifdef UART_RX_PARITY_EN
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_odd;
`endif
                        tcnt  <= '0;
                        bcnt  <= '0;
                        shreg <= '0;
                        state <= DATA;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end

            DATA: begin
               if (tick) begin
                  if (tcnt == T_END) begin
                     shreg[bcnt] <= rx_s;
                     tcnt        <= '0;
                     bcnt        <= bcnt + 3'd1;
                     if (bcnt == last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state <= par_en_q ? PARITY : STOP;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (tcnt == T_END) begin
                     par_bit <= rx_s;
                     tcnt    <= '0;
                     state   <= STOP;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end
`endif

            STOP: begin
               if (tick) begin
                  if (tcnt == T_END) begin
                     tcnt          <= '0;
                     rx_data       <= shreg;
                     rx_valid      <= 1'b1;
                     frame_error   <= ~rx_s;
                     overrun_error <= ~rx_ack & (overrun_error | rx_valid);
`ifdef UART_RX_PARITY_EN
                     parity_error  <= par_en_q & ((^shreg ^ par_bit) != par_odd_q);
`endif
                     state         <= rx_s ? IDLE : BREAK_WAIT;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end

            BREAK_WAIT: begin
               if (rx_s == UART_IDLE_LEVEL) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;

   localparam int OS       = 16;
   localparam int TDIV     = 4;
   localparam int BIT_CLKS = OS * TDIV;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick = 1'b0;
   logic       rx;
   logic [1:0] data_len;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       overrun_error;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_en;
   logic       parity_odd;
   logic       parity_error;
`endif

   uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .tick          (tick),
      .rx            (rx),
      .data_len      (data_len),
      .rx_ack        (rx_ack),
`ifdef UART_RX_PARITY_EN
      .parity_en     (parity_en),
      .parity_odd    (parity_odd),
`endif
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .frame_error   (frame_error),
      .overrun_error (overrun_error),
`ifdef UART_RX_PARITY_EN
      .parity_error  (parity_error),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int tdiv = 0;
   always @(negedge clk) begin
      tdiv = (tdiv + 1) % TDIV;
      tick = (tdiv == 0);
   end

   int frame_cnt = 0;
   always @(posedge rx_valid) frame_cnt++;

   int total  = 0;
   int passes = 0;

   // Frame-level reference model.
   logic [7:0] exp_data  = '0;
   logic       exp_valid = 1'b0;
   logic       exp_fe    = 1'b0;
   logic       exp_ov    = 1'b0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   // Drives a frame; data_len is changed to len_after right after the start bit.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] len, input logic stop_bit,
                             input logic [1:0] len_after, input logic with_par, input logic par_bit);
      data_len = len;
      send_bit(1'b0);
      data_len = len_after;
      for (int i = 0; i < 5 + int'(len); i++) send_bit(d[i]);
      if (with_par) send_bit(par_bit);
      send_bit(stop_bit);
   endtask

   task automatic model_frame(input logic [7:0] d, input logic [1:0] len, input logic stop_bit);
      exp_data  = d & (8'hFF >> (3 - int'(len)));
      exp_fe    = ~stop_bit;
      exp_ov    = exp_ov | exp_valid;
      exp_valid = 1'b1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".data"},    rx_data,                 exp_data);
      check({tag, ".valid"},   {7'd0, rx_valid},        {7'd0, exp_valid});
      check({tag, ".ferr"},    {7'd0, frame_error},     {7'd0, exp_fe});
      check({tag, ".overrun"}, {7'd0, overrun_error},   {7'd0, exp_ov});
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      @(negedge clk);
      exp_valid = 1'b0;
      exp_fe    = 1'b0;
      exp_ov    = 1'b0;
   endtask

   task automatic idle_gap(input int clks);
      rx = 1'b1;
      repeat (clks) @(negedge clk);
   endtask

   initial begin
      int busy_clks;
      int fc0;
      logic [7:0] d;
      logic [1:0] len, len2;
      logic       stop_bit;

      reset_n  = 1'b0;
      rx       = 1'b1;
      rx_ack   = 1'b0;
      data_len = 2'b11;
`ifdef UART_RX_PARITY_EN
      parity_en  = 1'b0;
      parity_odd = 1'b0;
`endif
      repeat (5) @(negedge clk);
      check("reset.data", rx_data, 8'h00);
      check("reset.valid", {7'd0, rx_valid}, 8'd0);
      check("reset.ferr", {7'd0, frame_error}, 8'd0);
      check("reset.overrun", {7'd0, overrun_error}, 8'd0);
      check("reset.busy", {7'd0, busy}, 8'd0);
      reset_n = 1'b1;
      idle_gap(20);

      // 8-bit frame 0xA5 with a good stop bit.
      send_frame(8'hA5, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0);
      model_frame(8'hA5, 2'b11, 1'b1);
      check_model("a5");
      check("a5.busy", {7'd0, busy}, 8'd0);
      do_ack();
      check("a5.ack_valid", {7'd0, rx_valid}, 8'd0);
      idle_gap(16);

      // 5-bit frame: upper bits must read zero.
      send_frame(8'hF3, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
      model_frame(8'hF3, 2'b00, 1'b1);
      check("len5.data", rx_data, 8'h13);
      check_model("len5");
      do_ack();
      idle_gap(16);

      // Short low glitch is rejected as a false start.
      busy_clks = 0;
      rx = 1'b0;
      for (int i = 0; i < 3 * TDIV; i++) begin
         @(negedge clk);
         if (busy) busy_clks++;
      end
      rx = 1'b1;
      for (int i = 0; i < 2 * BIT_CLKS; i++) begin
         @(negedge clk);
         if (busy) busy_clks++;
      end
      check("glitch.valid", {7'd0, rx_valid}, 8'd0);
      check("glitch.busy", {7'd0, busy}, 8'd0);
      check("glitch.busy_len_ok",
            {7'd0, (busy_clks >= (OS / 2 - 1) * TDIV) && (busy_clks <= (OS / 2 + 1) * TDIV)}, 8'd1);

      // Stop bit low followed by a held-low line: one frame only.
      fc0 = frame_cnt;
      send_frame(8'h3C, 2'b11, 1'b0, 2'b11, 1'b0, 1'b0);
      repeat (40 * TDIV) @(negedge clk);
      model_frame(8'h3C, 2'b11, 1'b0);
      check_model("break");
      check("break.busy_held", {7'd0, busy}, 8'd1);
      check("break.one_frame", 8'(frame_cnt - fc0), 8'd1);
      idle_gap(16);
      check("break.busy_released", {7'd0, busy}, 8'd0);
      check("break.still_one", 8'(frame_cnt - fc0), 8'd1);
      do_ack();

      // Overrun: two frames with no acknowledge.
      send_frame(8'h11, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0);
      model_frame(8'h11, 2'b11, 1'b1);
      idle_gap(16);
      send_frame(8'h22, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0);
      model_frame(8'h22, 2'b11, 1'b1);
      check_model("overrun");
      check("overrun.flag", {7'd0, overrun_error}, 8'd1);
      do_ack();
      check("overrun.ack_valid", {7'd0, rx_valid}, 8'd0);
      check("overrun.ack_ov", {7'd0, overrun_error}, 8'd0);
      check("overrun.ack_fe", {7'd0, frame_error}, 8'd0);
      idle_gap(16);

      // Reset in the middle of the data bits of 0x55.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      repeat (BIT_CLKS / 3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midreset.busy", {7'd0, busy}, 8'd0);
      check("midreset.valid", {7'd0, rx_valid}, 8'd0);
      check("midreset.data", rx_data, 8'h00);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      idle_gap(16);
      send_frame(8'h99, 2'b11, 1'b1, 2'b11, 1'b0, 1'b0);
      model_frame(8'h99, 2'b11, 1'b1);
      check_model("after_reset");
      do_ack();
      idle_gap(16);

`ifdef UART_RX_PARITY_EN
      // Even parity expected (parity_odd=0); 0x07 has three ones, so parity bit 0 is wrong.
      parity_en  = 1'b1;
      parity_odd = 1'b0;
      send_frame(8'h07, 2'b11, 1'b1, 2'b11, 1'b1, 1'b0);
      parity_en  = 1'b0;
      model_frame(8'h07, 2'b11, 1'b1);
      check_model("parity");
      check("parity.err", {7'd0, parity_error}, 8'd1);
      do_ack();
      check("parity.ack", {7'd0, parity_error}, 8'd0);
      idle_gap(16);
`endif

      // Randomized frames: random data, length, stop bit, mid-frame length change, optional ack.
      for (int n = 0; n < 24; n++) begin
         d        = 8'($urandom);
         len      = 2'($urandom_range(0, 3));
         len2     = 2'($urandom_range(0, 3));
         stop_bit = ($urandom_range(0, 3) != 0);
         send_frame(d, len, stop_bit, len2, 1'b0, 1'b0);
         model_frame(d, len, stop_bit);
         idle_gap(16);
         check_model($sformatf("rand%0d", n));
         if ($urandom_range(0, 1) == 1) do_ack();
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
